rr_arb_16: RTL
==============

# rr_arb_16

Round-robin arbiter that drives the 4-bit `select` of the 16-input, 128-bit mux and sits directly upstream of it. It chooses one of 16 requesters, holds that choice stable behind a valid/ready handshake toward the downstream consumer of `mux_out`, and acknowledges the winning requester on transfer. Grant and select are registered, so the mux input choice changes only on clock edges.

## Interface
- `N_PORTS`, 16: number of requesters; fixed at 16 in this revision.
- `SEL_W`, 4: select width, equal to $clog2(N_PORTS).
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous reset, active-low.
- `req`  in  16  per-requester request; held high until the matching `ack` bit is seen.
- `lock`  in  16  per-requester lock, sampled only in a transfer cycle; present only with `RR_ARB_16_LOCK_EN`.
- `select`  out  `SEL_W`  registered mux select; drives mux `select`.
- `out_valid`  out  1  the mux output at `select` is a valid beat.
- `out_ready`  in  1  the downstream consumer accepts the beat.
- `ack`  out  16  one-hot transfer acknowledge; `ack[select] = out_valid & out_ready`, all other bits 0.

## Operation
- States:
  - IDLE: `out_valid=0`.
  - GRANT: `out_valid=1`, and `select` is frozen.
- A transfer occurs in any cycle with `out_valid & out_ready`.
- IDLE -> GRANT: when `|req`, pick the winner, register it into `select`, and set `out_valid`.
- GRANT with `!out_ready`: hold `select` and `out_valid`. `req` changes have no effect.
- GRANT with a transfer:
  - Assert `ack[select]` combinationally in the same cycle.
  - Set the priority pointer `ptr <= select`.
  - Re-arbitrate over `req & ~(1<<select)`. The requester just served is excluded for one cycle.
  - If a candidate exists, stay in GRANT with the new `select`; there is no bubble.
  - Otherwise go to IDLE.
- Winner rule: the first set bit scanning from `ptr+1` upward, wrapping modulo 16, so `ptr` itself has the lowest priority.
- Pointer arithmetic is 4-bit, and 15+1 wraps to 0.
- When `req` bits change in the same cycle as an arbitration, only the values sampled in that cycle count.
- Reset values:
  - `select=0`, `out_valid=0`, `ack=0`, state IDLE.
  - `ptr=15`, so requester 0 has the highest priority after reset.
- Reset assertion mid-GRANT: `out_valid` and `ack` drop asynchronously. No transfer is counted and the beat is discarded.

## Timing
- Request to valid: 1 cycle. A `req` seen at edge N gives `out_valid=1` with `select` set after edge N.
- `ack` has 0-cycle latency from the transfer cycle and is 1 cycle wide.
- Back-to-back transfers to different requesters sustain 1 beat/cycle.
- A single lone requester without lock gets at most 1 beat every 2 cycles, because of the exclusion cycle.
- `select` never changes while `out_valid & !out_ready`.

## Configuration
- `RR_ARB_16_LOCK_EN` defined:
  - The `lock` port exists.
  - If `lock[select]` is high in a transfer cycle and `req[select]` is high, the arbiter keeps the same `select`.
  - It stays in GRANT and leaves `ptr` unchanged. No exclusion is applied, so locked bursts run at 1 beat/cycle.
- Undefined: there is no `lock` port, and every transfer re-arbitrates as described in Operation.

## Structure
- Shared package `mux_pkg` holds:
  - `N_PORTS=16`, `SEL_W=4`, `DATA_W=128`.
  - `sel_t` (logic [SEL_W-1:0]).
  - The `arb_state_e` enum {IDLE, GRANT}.
- Sub-module `rr_pick_16`: purely combinational. Inputs are a 16-bit request vector and a 4-bit `ptr`. Outputs are `found` and a 4-bit index, computed by rotate, find-first-set, then un-rotate.
- Top level holds the state register, `ptr`, `select`, and the ack decode.

## Test plan
- Reset, then `req=16'h0001`, `out_ready=1`:
  - `select=0` and `out_valid=1` one cycle later.
  - `ack=16'h0001` in that cycle.
  - Next cycle `out_valid=0`.
- `req=16'hFFFF` held, `out_ready=1`, lock off: `select` sequence 0,1,2,…,15,0. Exactly one `ack` bit per cycle, with no gaps.
- `req=16'h8001` after `ptr=15`, with `out_ready` low for 5 cycles: `select=0` stays stable and `ack=0` for 5 cycles. When `out_ready` rises, `ack=16'h0001`, then `select=15`.
- Wrap check: `ptr=14` and `req=16'h4001` gives `select=0`, and the following pick gives `select=14`.
- `RR_ARB_16_LOCK_EN` with `req=16'h0024`, `lock[2]=1` for 3 transfers: `select=2` for 3 consecutive beats, then `select=5`.
- `rst_n` pulsed low mid-GRANT with `select=7`: `out_valid=0` and `ack=0` immediately. After release, `req=16'h0080` gives `select=7` again, since `ptr=15`.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared definitions for the 16-input x 128-bit mux and its round-robin select arbiter.
package mux_pkg;
  localparam int N_PORTS = 16;
  localparam int SEL_W   = 4;
  localparam int DATA_W  = 128;

  typedef logic [SEL_W-1:0] sel_t;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;
endpackage

// File: rtl/rr_pick_16.sv
// Combinational round-robin picker: first set request scanning upward from ptr+1,
// wrapping mod 16, so ptr itself is the lowest-priority position.
module rr_pick_16
  import mux_pkg::*;
(
  input  logic [N_PORTS-1:0] i_req,
  input  logic [SEL_W-1:0]   i_ptr,
  output logic               o_found,
  output logic [SEL_W-1:0]   o_idx
);
  sel_t               w_start;
  logic [N_PORTS-1:0] w_rot;
  sel_t               w_ffs;

  assign w_start = i_ptr + 1'b1;
  // Rotate so position ptr+1 lands at bit 0; a zero start shifts the left half out entirely.
  assign w_rot   = (i_req >> w_start) | (i_req << (5'd16 - {1'b0, w_start}));

  always_comb begin
    w_ffs = '0;
    for (int i = N_PORTS - 1; i >= 0; i--) begin
      if (w_rot[i]) w_ffs = sel_t'(i);
    end
  end

  assign o_found = |i_req;
  assign o_idx   = w_start + w_ffs;
endmodule

// File: rtl/rr_arb_16.sv
// Round-robin arbiter driving the 16:1 mux select behind a valid/ready handshake.
// Defining RR_ARB_16_LOCK_EN adds the lock port: a locked, still-requesting winner keeps the grant.
//   state | meaning
//   IDLE  | no beat presented, out_valid low
//   GRANT | beat valid at select; select frozen until out_ready
module rr_arb_16
  import mux_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_PORTS-1:0] req,
`ifdef RR_ARB_16_LOCK_EN
  input  logic [N_PORTS-1:0] lock,
`endif
  output logic [SEL_W-1:0]   select,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N_PORTS-1:0] ack
);
  arb_state_e         r_state, w_state_nxt;
  sel_t               r_ptr, w_ptr_nxt;
  sel_t               r_select, w_select_nxt;
  logic               w_xfer;
  logic               w_hold_lock;
  logic               w_found;
  logic [N_PORTS-1:0] w_cand;
  sel_t               w_pick_ptr;
  sel_t               w_pick_idx;

  assign w_xfer = (r_state == GRANT) && out_ready;

`ifdef RR_ARB_16_LOCK_EN
  assign w_hold_lock = lock[r_select] & req[r_select];
`else
  assign w_hold_lock = 1'b0;
`endif

  // On a transfer the served requester sits out one pick and becomes the new pointer.
  assign w_cand     = (r_state == GRANT) ? (req & ~(N_PORTS'(1) << r_select)) : req;
  assign w_pick_ptr = (r_state == GRANT) ? r_select : r_ptr;

  rr_pick_16 u_pick (
    .i_req   (w_cand),
    .i_ptr   (w_pick_ptr),
    .o_found (w_found),
    .o_idx   (w_pick_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_ptr    <= '1;
      r_select <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_ptr    <= w_ptr_nxt;
      r_select <= w_select_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_ptr_nxt    = r_ptr;
    w_select_nxt = r_select;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_state_nxt  = GRANT;
          w_select_nxt = w_pick_idx;
        end
      end
      GRANT: begin
        if (out_ready && !w_hold_lock) begin
          w_ptr_nxt = r_select;
          if (w_found) w_select_nxt = w_pick_idx;
          else         w_state_nxt  = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    out_valid = (r_state == GRANT);
    ack       = '0;
    if (w_xfer) ack[r_select] = 1'b1;
  end

  assign select = r_select;
endmodule
